// File: rtl/key_evt_pkg.sv
// key_evt_pkg: shared output-state encoding and index-width helper for key_event_arbiter.
`default_nettype none

package key_evt_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic int key_idx_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_event_arbiter_if.sv
// key_event_arbiter_if: key strobe inputs and event valid/ready output bundle.
`default_nettype none

interface key_event_arbiter_if #(
  parameter int KEY_NUM = 4
);
  localparam int KEY_IDX_W = key_evt_pkg::key_idx_w(KEY_NUM);

  logic [KEY_NUM-1:0]   key_stb_i;
  logic                 evt_valid_o;
  logic [KEY_IDX_W-1:0] evt_key_o;
  logic                 evt_ready_i;
  logic                 overrun_o;

  // slave: the arbiter; master: key source plus event consumer
  modport slave (
    input  key_stb_i,
    input  evt_ready_i,
    output evt_valid_o,
    output evt_key_o,
    output overrun_o
  );

  modport master (
    output key_stb_i,
    output evt_ready_i,
    input  evt_valid_o,
    input  evt_key_o,
    input  overrun_o
  );
endinterface

`default_nettype wire

// File: rtl/key_event_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last_grant+1 with wrap.
`default_nettype none

module rr_arbiter
  import key_evt_pkg::*;
#(
  parameter int KEY_NUM = 4,
  localparam int IDX_W  = key_idx_w(KEY_NUM)
) (
  input  wire logic [KEY_NUM-1:0] i_req,
  input  wire logic [IDX_W-1:0]   i_last_grant,
  output logic                    o_grant_valid,
  output logic [IDX_W-1:0]        o_grant_idx
);

  int w_cand;

  // Walk candidates furthest-first so the nearest requester after last_grant wins.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    w_cand        = 0;
    for (int i = KEY_NUM; i >= 1; i--) begin
      w_cand = (int'(i_last_grant) + i) % KEY_NUM;
      if (i_req[IDX_W'(w_cand)]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = IDX_W'(w_cand);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/key_event_arbiter.sv
// key_event_arbiter: records key strobes as pending presses and emits them one at a time over valid/ready.
// Optional macro KEY_EVT_OVR_CNT_EN adds the saturating overrun counter output ovr_cnt_o.
`default_nettype none

module key_event_arbiter
  import key_evt_pkg::*;
#(
  parameter int KEY_NUM   = 4,
  parameter int OVR_CNT_W = 8
) (
  input  wire logic              clk_i,
  input  wire logic              rst_ni,
  key_event_arbiter_if.slave     bus
`ifdef KEY_EVT_OVR_CNT_EN
  ,
  output logic [OVR_CNT_W-1:0]   ovr_cnt_o
`endif
);

  localparam int KEY_IDX_W = key_idx_w(KEY_NUM);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [KEY_NUM-1:0]   r_pend;
  logic [KEY_IDX_W-1:0] r_last;
  logic [KEY_IDX_W-1:0] r_key;
  logic                 r_ovr;

  logic                 w_load;
  logic                 w_arb_valid;
  logic [KEY_IDX_W-1:0] w_arb_idx;
  logic                 w_grant;
  logic [KEY_NUM-1:0]   w_clr;
  logic                 w_ovr;

  rr_arbiter #(
    .KEY_NUM (KEY_NUM)
  ) u_rr (
    .i_req         (r_pend),
    .i_last_grant  (r_last),
    .o_grant_valid (w_arb_valid),
    .o_grant_idx   (w_arb_idx)
  );

  assign w_load  = (r_state == EMPTY) || bus.evt_ready_i;
  assign w_grant = w_load && w_arb_valid;
  assign w_clr   = w_grant ? (KEY_NUM'(1) << w_arb_idx) : '0;
  // A strobe on the key being granted this edge simply re-arms it; only a truly held bit overruns.
  assign w_ovr   = |(bus.key_stb_i & r_pend & ~w_clr);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_grant) w_state_nxt = FULL;
      FULL:    if (bus.evt_ready_i && !w_grant) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= EMPTY;
      r_pend  <= '0;
      r_last  <= KEY_IDX_W'(KEY_NUM - 1);
      r_key   <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= (r_pend & ~w_clr) | bus.key_stb_i;
      r_ovr   <= w_ovr;
      if (w_grant) begin
        r_key  <= w_arb_idx;
        r_last <= w_arb_idx;
      end
    end
  end

  assign bus.evt_valid_o = (r_state == FULL);
  assign bus.evt_key_o   = r_key;
  assign bus.overrun_o   = r_ovr;

`ifdef KEY_EVT_OVR_CNT_EN
  logic [OVR_CNT_W-1:0] r_ovr_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ovr_cnt <= '0;
    end else if (w_ovr && (r_ovr_cnt != {OVR_CNT_W{1'b1}})) begin
      r_ovr_cnt <= r_ovr_cnt + 1'b1;
    end
  end

  assign ovr_cnt_o = r_ovr_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_key_event_arbiter.sv
// tb_key_event_arbiter: directed steps with an expected-key scoreboard drained on each handshake.
`default_nettype none

module tb_key_event_arbiter;
  localparam int KN    = 4;
  localparam int OVR_W = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errs;
  int   n_ovr;
  int   exp_key;
  logic hs;
  int   hs_key;
  int   q[$];

  key_event_arbiter_if #(.KEY_NUM(KN)) bus ();

`ifdef KEY_EVT_OVR_CNT_EN
  logic [OVR_W-1:0] ovr_cnt;
`endif

  key_event_arbiter #(
    .KEY_NUM   (KN),
    .OVR_CNT_W (OVR_W)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
`ifdef KEY_EVT_OVR_CNT_EN
    ,
    .ovr_cnt_o (ovr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, score a handshake seen before the edge, then sample after it.
  task automatic cyc(input logic [KN-1:0] stb, input logic rdy);
    bus.key_stb_i   = stb;
    bus.evt_ready_i = rdy;
    hs     = bus.evt_valid_o && rdy && rst_n;
    hs_key = int'(bus.evt_key_o);
    @(posedge clk);
    #1;
    if (hs) begin
      if (q.size() == 0) begin
        checks++;
        errs++;
        $error("FAIL unexpected_evt: got key %0d expected no event", hs_key);
      end else begin
        exp_key = q.pop_front();
        check("evt_key", hs_key, exp_key);
      end
    end
    if (bus.overrun_o === 1'b1) n_ovr++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc('0, 1'b0);
    cyc('0, 1'b0);
    rst_n = 1'b1;
    q.delete();
    n_ovr = 0;
  endtask

  initial begin
    checks = 0;
    errs   = 0;
    n_ovr  = 0;
    rst_n  = 1'b0;
    bus.key_stb_i   = '0;
    bus.evt_ready_i = 1'b0;

    // Reset state
    do_reset();
    check("rst_valid", int'(bus.evt_valid_o), 0);
    check("rst_key", int'(bus.evt_key_o), 0);
    check("rst_ovr", int'(bus.overrun_o), 0);
`ifdef KEY_EVT_OVR_CNT_EN
    check("rst_cnt", int'(ovr_cnt), 0);
`endif

    // Single press on key 2: pending after edge 0, valid after edge 1, idle after edge 2
    cyc(4'b0100, 1'b1);
    check("single_lat0", int'(bus.evt_valid_o), 0);
    q.push_back(2);
    cyc('0, 1'b1);
    check("single_valid", int'(bus.evt_valid_o), 1);
    check("single_key", int'(bus.evt_key_o), 2);
    cyc('0, 1'b1);
    check("single_done", int'(bus.evt_valid_o), 0);
    check("single_q", q.size(), 0);

    // Simultaneous keys 0,1,3 from a fresh reset
    do_reset();
    q.push_back(0); q.push_back(1); q.push_back(3);
    cyc(4'b1011, 1'b1);
    for (int i = 0; i < 4; i++) cyc('0, 1'b1);
    check("simul_q", q.size(), 0);
    check("simul_valid", int'(bus.evt_valid_o), 0);
    check("simul_ovr", n_ovr, 0);

    // Fairness: keys 0 and 1 every cycle for 8 cycles -> 9 alternating events, 7 overruns
    do_reset();
    for (int i = 0; i < 9; i++) q.push_back(i % 2);
    for (int i = 0; i < 8; i++) cyc(4'b0011, 1'b1);
    for (int i = 0; i < 4; i++) cyc('0, 1'b1);
    check("fair_q", q.size(), 0);
    check("fair_ovr", n_ovr, 7);

    // Backpressure on key 1 with a repeat press that overruns
    do_reset();
    cyc(4'b0010, 1'b1);
    cyc('0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc((i == 2 || i == 4) ? 4'b0010 : 4'b0000, 1'b0);
      check("bp_valid", int'(bus.evt_valid_o), 1);
      check("bp_key", int'(bus.evt_key_o), 1);
      if (i == 4) begin
        check("bp_ovr_pulse", int'(bus.overrun_o), 1);
`ifdef KEY_EVT_OVR_CNT_EN
        check("bp_cnt", int'(ovr_cnt), 1);
`endif
      end
      if (i == 5) check("bp_ovr_end", int'(bus.overrun_o), 0);
    end
    check("bp_ovr_total", n_ovr, 1);
    q.push_back(1); q.push_back(1);
    for (int i = 0; i < 3; i++) cyc('0, 1'b1);
    check("bp_q", q.size(), 0);
    check("bp_idle", int'(bus.evt_valid_o), 0);

    // Reset while holding key 0 with keys 1,2 pending; strobes during reset are ignored
    do_reset();
    cyc(4'b0111, 1'b0);
    cyc('0, 1'b0);
    check("mid_valid", int'(bus.evt_valid_o), 1);
    rst_n = 1'b0;
    cyc(4'b0101, 1'b1);
    rst_n = 1'b1;
    check("mid_rst_valid", int'(bus.evt_valid_o), 0);
    for (int i = 0; i < 5; i++) cyc('0, 1'b1);
    check("mid_quiet", int'(bus.evt_valid_o), 0);

    // Saturation: key 3 strobed each cycle against a stalled output -> 5 overruns
    do_reset();
    for (int i = 0; i < 7; i++) cyc(4'b1000, 1'b0);
    check("sat_ovr", n_ovr, 5);
`ifdef KEY_EVT_OVR_CNT_EN
    check("sat_cnt", int'(ovr_cnt), 3);
`endif
    q.push_back(3); q.push_back(3);
    for (int i = 0; i < 3; i++) cyc('0, 1'b1);
    check("sat_q", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/key_event_arbiter.md
KEY_EVENT_ARBITER -- requirements
Module: key_event_arbiter

Interface
REQ-001 The block SHALL have parameter KEY_NUM, default 4, number of key strobe inputs (legal 2..16).
REQ-002 The block SHALL have parameter OVR_CNT_W, default 8, overrun counter width.
REQ-003 The block SHALL have port clk_i  input  1  clock; single clock domain.
REQ-004 The block SHALL have port rst_ni  input  1  reset; synchronous, active-low.
REQ-005 The block SHALL have port key_stb_i  input  KEY_NUM  one-cycle press strobes, one per key, already debounced and synchronous to clk_i.
REQ-006 The block SHALL have port evt_valid_o  output  1  event available.
REQ-007 The block SHALL have port evt_key_o  output  KEY_IDX_W  index of the pressed key; KEY_IDX_W = $clog2(KEY_NUM).
REQ-008 The block SHALL have port evt_ready_i  input  1  consumer accepts the event.
REQ-009 The block SHALL have port overrun_o  output  1  one-cycle pulse on a lost press.

Function
REQ-010 A strobe on key k at clock edge t SHALL set pending[k], visible after edge t.
REQ-011 The output register SHALL be loadable when evt_valid_o=0, or when evt_valid_o=1 and evt_ready_i=1 (same-cycle reload).
REQ-012 On a loadable edge with any pending bit set, the block SHALL grant one key round-robin, searching from (last_grant+1) mod KEY_NUM upward with wrap.
REQ-013 The grant SHALL load evt_key_o, set evt_valid_o, clear that pending bit and update last_grant in the same edge.
REQ-014 Latency SHALL be 2 edges from strobe to evt_valid_o when the output is idle: strobe sampled at t, pending after t, valid after t+1.
REQ-015 With evt_ready_i held high, throughput SHALL be one event per clock.
REQ-016 While evt_valid_o=1 and evt_ready_i=0, evt_valid_o and evt_key_o SHALL hold stable.
REQ-017 Handshake completion SHALL occur on an edge with evt_valid_o=1 and evt_ready_i=1; with nothing pending at that edge, evt_valid_o SHALL go 0.
REQ-018 A strobe on key k at an edge where pending[k] is already set and not being granted SHALL leave pending[k] set and pulse overrun_o for one cycle, registered.
REQ-019 A strobe on key k at the same edge pending[k] is granted SHALL re-set pending[k] with no overrun.
REQ-020 A key currently held in the output register SHALL NOT block a new strobe on that key; the strobe sets pending.
REQ-021 Simultaneous strobes on several keys SHALL all be recorded; they are served in round-robin order.
REQ-022 The output state machine SHALL have states EMPTY and FULL: EMPTY->FULL on grant; FULL->EMPTY on handshake with nothing pending; FULL->FULL on handshake with a grant or on stall.

Reset
REQ-023 On an edge with rst_ni=0, the block SHALL clear pending, set last_grant=KEY_NUM-1 (first search starts at key 0), set state EMPTY, evt_valid_o=0, evt_key_o=0, overrun_o=0 and the overrun counter to 0.
REQ-024 Reset mid-handshake SHALL discard the held event and all pending presses; strobes during reset SHALL be ignored.

Configuration
REQ-025 With macro KEY_EVT_OVR_CNT_EN defined, the block SHALL add output port ovr_cnt_o, OVR_CNT_W wide, holding a count of overrun_o pulses that saturates at all-ones and clears only on reset.
REQ-026 Without KEY_EVT_OVR_CNT_EN, port ovr_cnt_o and its counter SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-027 Package key_evt_pkg SHALL hold the state enum (EMPTY, FULL) and function key_idx_w(n) returning max(1,$clog2(n)).
REQ-028 Round-robin selection SHALL live in sub-module rr_arbiter (inputs req vector and last_grant; outputs grant_valid and grant_idx), combinational and parameterized by KEY_NUM.

Verification
REQ-029 Single press: KEY_NUM=4, ready=1, strobe key 2 at edge 0 -> evt_valid_o=1, evt_key_o=2 after edge 1, valid=0 after edge 2.
REQ-030 Simultaneous press: strobe keys 0,1,3 on one edge, ready=1 -> events 0,1,3 on consecutive cycles, no overrun.
REQ-031 Fairness: keys 0 and 1 strobed every cycle, ready=1 -> evt_key_o alternates 0,1,0,1 and overrun_o pulses on each non-granted repeat.
REQ-032 Backpressure: ready=0 for 10 cycles after valid on key 1 -> evt_key_o stays 1; a second strobe on key 1 while pending is set -> overrun_o=1 for one cycle, and ovr_cnt_o=1 with the macro defined.
REQ-033 Reset mid-operation: valid=1 with two pending keys, rst_ni=0 for one edge -> valid=0 and no events emerge afterwards without new strobes.
REQ-034 Saturation: with macro defined and OVR_CNT_W=2, 5 overruns -> ovr_cnt_o=3.
